pipe_hazard_ctrl: RTL and testbench

//  Pipeline control unit driving the hold/scour (flush) flags of PC, IF/ID and ID/EX.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 19 +
 rtl/pipe_hazard_ctrl.sv | 132 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared opcode constants and control types for the pipeline hazard controller.
// Branch/jump opcodes are kept here for the decode and EX stages that share this package.
package pipe_hazard_ctrl_pkg;

   typedef logic [4:0]  reg_addr_t;
   typedef logic [31:0] inst_addr_t;
   typedef logic [6:0]  opcode_t;

   localparam opcode_t OPC_LOAD   = 7'b0000011;
   localparam opcode_t OPC_BRANCH = 7'b1100011;
   localparam opcode_t OPC_JAL    = 7'b1101111;
   localparam opcode_t OPC_JALR   = 7'b1100111;

   typedef enum logic {
      RUN      = 1'b0,
      MDU_WAIT = 1'b1
   } ctrl_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl.sv
// Hold/flush/redirect control for PC, IF/ID and ID/EX: load-use bubbles, MDU waits
// with a watchdog, branch mispredict redirects and a saturating stall-cycle counter.
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int MDU_TIMEOUT = 64,
   parameter int CNT_W       = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  opcode_t           ctrl_opcode_i,
   input  reg_addr_t         ex_addr_i,
   input  logic              ex_we_i,
   input  reg_addr_t         id_addr1_i,
   input  reg_addr_t         id_addr2_i,
   input  logic              id_re1_i,
   input  logic              id_re2_i,
   input  logic              ex_jump_i,
   input  logic              ex_jump_bp_i,
   input  inst_addr_t        ex_jump_addr_i,
   input  inst_addr_t        ex_pc_i,
   input  logic              ex_mdu_start_i,
   input  logic              ex_mdu_done_i,
   output logic              pc_hold_o,
   output logic              id_hold_flag_o,
   output logic              ex_hold_flag_o,
   output logic              id_scour_flag_o,
   output logic              ex_scour_flag_o,
   output logic              pc_jump_o,
   output inst_addr_t        pc_jump_addr_o,
   output logic              mdu_timeout_o,
   output logic [CNT_W-1:0]  stall_cnt_o,
   output ctrl_state_e       dbg_state_o
);

   localparam int WD_W = $clog2(MDU_TIMEOUT + 1);

   ctrl_state_e     state;
   logic [WD_W-1:0] wd_cnt;
   logic            mispredict;
   logic            load_use;
   logic            wd_expired;

   assign mispredict = (ex_jump_i != ex_jump_bp_i);
   assign wd_expired = (wd_cnt == WD_W'(MDU_TIMEOUT));
   // Writes to x0 are discarded, so a load targeting rd=0 never creates a dependency.
   assign load_use   = (ctrl_opcode_i == OPC_LOAD) && ex_we_i && (ex_addr_i != 5'd0) &&
                       ((id_re1_i && (id_addr1_i == ex_addr_i)) ||
                        (id_re2_i && (id_addr2_i == ex_addr_i)));
   assign dbg_state_o = state;

   always_comb begin
      pc_hold_o       = 1'b0;
      id_hold_flag_o  = 1'b0;
      ex_hold_flag_o  = 1'b0;
      id_scour_flag_o = 1'b0;
      ex_scour_flag_o = 1'b0;
      pc_jump_o       = 1'b0;
      pc_jump_addr_o  = '0;
      if (!rst) begin
         case (state)
            RUN: begin
               if (mispredict) begin
                  pc_jump_o       = 1'b1;
                  pc_jump_addr_o  = ex_jump_i ? ex_jump_addr_i : ex_pc_i + 32'd4;
                  id_scour_flag_o = 1'b1;
                  ex_scour_flag_o = 1'b1;
               end else if (ex_mdu_start_i) begin
                  pc_hold_o      = 1'b1;
                  id_hold_flag_o = 1'b1;
                  ex_hold_flag_o = 1'b1;
               end else if (load_use) begin
                  pc_hold_o       = 1'b1;
                  id_hold_flag_o  = 1'b1;
                  ex_scour_flag_o = 1'b1;
               end
            end
            MDU_WAIT: begin
               // EX is frozen here, so start and mispredict inputs are stale and ignored.
               if (!ex_mdu_done_i) begin
                  if (wd_expired) begin
                     ex_scour_flag_o = 1'b1;
                  end else begin
                     pc_hold_o      = 1'b1;
                     id_hold_flag_o = 1'b1;
                     ex_hold_flag_o = 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= RUN;
         wd_cnt        <= '0;
         mdu_timeout_o <= 1'b0;
         stall_cnt_o   <= '0;
      end else begin
         case (state)
            RUN: begin
               if (!mispredict && ex_mdu_start_i) begin
                  state  <= MDU_WAIT;
                  wd_cnt <= WD_W'(1);
               end
            end
            MDU_WAIT: begin
               if (ex_mdu_done_i) begin
                  state  <= RUN;
                  wd_cnt <= '0;
               end else if (wd_expired) begin
                  state         <= RUN;
                  wd_cnt        <= '0;
                  mdu_timeout_o <= 1'b1;
               end else begin
                  wd_cnt <= wd_cnt + WD_W'(1);
               end
            end
            default: begin
               state  <= RUN;
               wd_cnt <= '0;
            end
         endcase
         if (pc_hold_o && (stall_cnt_o != {CNT_W{1'b1}})) begin
            stall_cnt_o <= stall_cnt_o + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances (default watchdog, and a short watchdog with
// a 3-bit counter) share stimulus and are checked every cycle against a behavioural model.
module tb_pipe_hazard_ctrl;
   import pipe_hazard_ctrl_pkg::*;

   typedef struct packed {
      logic        pc_hold;
      logic        id_hold;
      logic        ex_hold;
      logic        id_sc;
      logic        ex_sc;
      logic        pc_jump;
      logic [31:0] addr;
      logic        to;
      logic [31:0] cnt;
      logic        st;
   } obs_t;

   logic        clk = 1'b0;
   logic        rst;
   opcode_t     ctrl_opcode;
   reg_addr_t   ex_addr, id_addr1, id_addr2;
   logic        ex_we, id_re1, id_re2, ex_jump, ex_jump_bp, mdu_start, mdu_done;
   inst_addr_t  ex_jump_addr, ex_pc;

   logic        pc_hold_a, id_hold_a, ex_hold_a, id_sc_a, ex_sc_a, pc_jump_a, to_a;
   inst_addr_t  addr_a;
   logic [31:0] cnt_a;
   ctrl_state_e st_a;
   logic        pc_hold_t, id_hold_t, ex_hold_t, id_sc_t, ex_sc_t, pc_jump_t, to_t;
   inst_addr_t  addr_t;
   logic [2:0]  cnt_t;
   ctrl_state_e st_t;

   obs_t obs_a, obs_t_;
   assign obs_a  = {pc_hold_a, id_hold_a, ex_hold_a, id_sc_a, ex_sc_a, pc_jump_a, addr_a,
                    to_a, cnt_a, st_a == MDU_WAIT};
   assign obs_t_ = {pc_hold_t, id_hold_t, ex_hold_t, id_sc_t, ex_sc_t, pc_jump_t, addr_t,
                    to_t, {29'd0, cnt_t}, st_t == MDU_WAIT};

   int total = 0;
   int bad   = 0;

   // clock / reset
   always #5 clk = ~clk;
   initial begin
      #200000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "bench timeout");
   end

   pipe_hazard_ctrl #(.MDU_TIMEOUT(64), .CNT_W(32)) dut_a (
      .clk(clk), .rst(rst), .ctrl_opcode_i(ctrl_opcode), .ex_addr_i(ex_addr), .ex_we_i(ex_we),
      .id_addr1_i(id_addr1), .id_addr2_i(id_addr2), .id_re1_i(id_re1), .id_re2_i(id_re2),
      .ex_jump_i(ex_jump), .ex_jump_bp_i(ex_jump_bp), .ex_jump_addr_i(ex_jump_addr),
      .ex_pc_i(ex_pc), .ex_mdu_start_i(mdu_start), .ex_mdu_done_i(mdu_done),
      .pc_hold_o(pc_hold_a), .id_hold_flag_o(id_hold_a), .ex_hold_flag_o(ex_hold_a),
      .id_scour_flag_o(id_sc_a), .ex_scour_flag_o(ex_sc_a), .pc_jump_o(pc_jump_a),
      .pc_jump_addr_o(addr_a), .mdu_timeout_o(to_a), .stall_cnt_o(cnt_a), .dbg_state_o(st_a));

   pipe_hazard_ctrl #(.MDU_TIMEOUT(4), .CNT_W(3)) dut_t (
      .clk(clk), .rst(rst), .ctrl_opcode_i(ctrl_opcode), .ex_addr_i(ex_addr), .ex_we_i(ex_we),
      .id_addr1_i(id_addr1), .id_addr2_i(id_addr2), .id_re1_i(id_re1), .id_re2_i(id_re2),
      .ex_jump_i(ex_jump), .ex_jump_bp_i(ex_jump_bp), .ex_jump_addr_i(ex_jump_addr),
      .ex_pc_i(ex_pc), .ex_mdu_start_i(mdu_start), .ex_mdu_done_i(mdu_done),
      .pc_hold_o(pc_hold_t), .id_hold_flag_o(id_hold_t), .ex_hold_flag_o(ex_hold_t),
      .id_scour_flag_o(id_sc_t), .ex_scour_flag_o(ex_sc_t), .pc_jump_o(pc_jump_t),
      .pc_jump_addr_o(addr_t), .mdu_timeout_o(to_t), .stall_cnt_o(cnt_t), .dbg_state_o(st_t));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // scoreboard: behavioural model per instance
   int     to_lim[2] = '{64, 4};
   longint cnt_max[2] = '{64'hFFFF_FFFF, 64'd7};
   bit     m_busy[2];
   int     m_wait[2];
   bit     m_to[2];
   longint m_cnt[2];
   bit     m_mis, m_lu;
   obs_t   e, a;

   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         a = (k == 0) ? obs_a : obs_t_;
         e = '0;
         if (rst) begin
            m_busy[k] = 0; m_wait[k] = 0; m_to[k] = 0; m_cnt[k] = 0;
         end else begin
            e.to  = m_to[k];
            e.cnt = m_cnt[k][31:0];
            e.st  = m_busy[k];
            m_mis = (ex_jump != ex_jump_bp);
            m_lu  = (ctrl_opcode == 7'b0000011) && ex_we && (ex_addr != 0) &&
                    ((id_re1 && id_addr1 == ex_addr) || (id_re2 && id_addr2 == ex_addr));
            if (!m_busy[k]) begin
               if (m_mis) begin
                  e.pc_jump = 1; e.id_sc = 1; e.ex_sc = 1;
                  e.addr = ex_jump ? ex_jump_addr : ex_pc + 32'd4;
               end else if (mdu_start) begin
                  e.pc_hold = 1; e.id_hold = 1; e.ex_hold = 1;
                  m_busy[k] = 1; m_wait[k] = 1;
               end else if (m_lu) begin
                  e.pc_hold = 1; e.id_hold = 1; e.ex_sc = 1;
               end
            end else if (mdu_done) begin
               m_busy[k] = 0;
            end else if (m_wait[k] == to_lim[k]) begin
               e.ex_sc = 1; m_busy[k] = 0; m_to[k] = 1;
            end else begin
               e.pc_hold = 1; e.id_hold = 1; e.ex_hold = 1;
               m_wait[k]++;
            end
            if (e.pc_hold && m_cnt[k] < cnt_max[k]) m_cnt[k]++;
         end
         chk($sformatf("m%0d_pc_hold", k), 32'(a.pc_hold), 32'(e.pc_hold));
         chk($sformatf("m%0d_id_hold", k), 32'(a.id_hold), 32'(e.id_hold));
         chk($sformatf("m%0d_ex_hold", k), 32'(a.ex_hold), 32'(e.ex_hold));
         chk($sformatf("m%0d_id_scour", k), 32'(a.id_sc), 32'(e.id_sc));
         chk($sformatf("m%0d_ex_scour", k), 32'(a.ex_sc), 32'(e.ex_sc));
         chk($sformatf("m%0d_pc_jump", k), 32'(a.pc_jump), 32'(e.pc_jump));
         chk($sformatf("m%0d_jump_addr", k), a.addr, e.addr);
         chk($sformatf("m%0d_timeout", k), 32'(a.to), 32'(e.to));
         chk($sformatf("m%0d_stall_cnt", k), a.cnt, e.cnt);
         chk($sformatf("m%0d_state", k), 32'(a.st), 32'(e.st));
      end
   end

   // driver tasks
   task automatic idle();
      ctrl_opcode = 7'd0; ex_addr = 5'd0; ex_we = 0; id_addr1 = 5'd0; id_addr2 = 5'd0;
      id_re1 = 0; id_re2 = 0; ex_jump = 0; ex_jump_bp = 0; ex_jump_addr = 32'd0;
      ex_pc = 32'd0; mdu_start = 0; mdu_done = 0;
   endtask

   task automatic load(input logic [4:0] rd, input logic [4:0] rs1, input logic re1,
                       input logic [4:0] rs2, input logic re2);
      ctrl_opcode = 7'b0000011; ex_we = 1; ex_addr = rd;
      id_addr1 = rs1; id_re1 = re1; id_addr2 = rs2; id_re2 = re2;
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   initial begin
      rst = 1; idle();
      adv(); adv(); settle();
      chk("rst_pc_hold", 32'(pc_hold_a), 32'd0);
      chk("rst_stall_cnt", cnt_a, 32'd0);
      chk("rst_timeout", 32'(to_a), 32'd0);
      adv(); rst = 0;

      // load-use on rs1
      load(5'd5, 5'd5, 1, 5'd0, 0); settle();
      chk("lu_pc_hold", 32'(pc_hold_a), 32'd1);
      chk("lu_id_hold", 32'(id_hold_a), 32'd1);
      chk("lu_ex_scour", 32'(ex_sc_a), 32'd1);
      chk("lu_ex_hold", 32'(ex_hold_a), 32'd0);
      adv(); idle(); settle();
      chk("lu_after_hold", 32'(pc_hold_a), 32'd0);
      chk("lu_after_scour", 32'(ex_sc_a), 32'd0);
      chk("lu_cnt", cnt_a, 32'd1);
      adv(); load(5'd0, 5'd0, 1, 5'd0, 0); settle();
      chk("lu_x0", 32'(pc_hold_a), 32'd0);
      adv(); load(5'd5, 5'd0, 0, 5'd5, 0); settle();
      chk("lu_re2_off", 32'(pc_hold_a), 32'd0);
      adv(); load(5'd7, 5'd1, 1, 5'd7, 1);
      adv(); load(5'd7, 5'd7, 1, 5'd7, 1); ex_we = 0;
      adv(); load(5'd7, 5'd7, 1, 5'd0, 0); ctrl_opcode = OPC_BRANCH;

      // mispredict redirects
      adv(); idle(); ex_jump = 1; ex_jump_bp = 0; ex_jump_addr = 32'h100; settle();
      chk("mp_jump", 32'(pc_jump_a), 32'd1);
      chk("mp_addr", addr_a, 32'h100);
      chk("mp_id_scour", 32'(id_sc_a), 32'd1);
      chk("mp_ex_scour", 32'(ex_sc_a), 32'd1);
      chk("mp_no_hold", 32'(pc_hold_a), 32'd0);
      adv(); idle(); ex_jump = 0; ex_jump_bp = 1; ex_pc = 32'hFFFF_FFFC; settle();
      chk("mp_wrap_jump", 32'(pc_jump_a), 32'd1);
      chk("mp_wrap_addr", addr_a, 32'h0);
      adv(); idle(); ex_jump = 1; ex_jump_bp = 1; ex_jump_addr = 32'h200; settle();
      chk("mp_correct", 32'(pc_jump_a), 32'd0);
      adv(); load(5'd3, 5'd3, 1, 5'd0, 0); ex_jump = 1; ex_jump_bp = 0;
      ex_jump_addr = 32'h40; mdu_start = 1; settle();
      chk("prio_jump", 32'(pc_jump_a), 32'd1);
      chk("prio_no_hold", 32'(pc_hold_a), 32'd0);
      adv(); idle(); settle();
      chk("prio_state", 32'(st_a), 32'(RUN));

      // MDU: done five cycles after start; short-watchdog instance aborts first
      adv(); rst = 1; adv(); rst = 0;
      mdu_start = 1; settle();
      chk("mdu_start_pc", 32'(pc_hold_a), 32'd1);
      chk("mdu_start_id", 32'(id_hold_a), 32'd1);
      chk("mdu_start_ex", 32'(ex_hold_a), 32'd1);
      adv(); idle();
      for (int i = 1; i <= 4; i++) begin
         if (i == 2) begin ex_jump = 1; ex_jump_bp = 0; mdu_start = 1; end
         settle();
         chk($sformatf("mdu_wait%0d_hold", i), 32'(pc_hold_a), 32'd1);
         chk($sformatf("mdu_wait%0d_jump", i), 32'(pc_jump_a), 32'd0);
         if (i == 4) begin
            chk("wd_abort_hold", 32'(pc_hold_t), 32'd0);
            chk("wd_abort_scour", 32'(ex_sc_t), 32'd1);
         end
         adv(); idle();
      end
      mdu_done = 1; settle();
      chk("mdu_done_pc", 32'(pc_hold_a), 32'd0);
      chk("mdu_done_id", 32'(id_hold_a), 32'd0);
      chk("mdu_done_ex", 32'(ex_hold_a), 32'd0);
      chk("wd_flag", 32'(to_t), 32'd1);
      adv(); idle(); settle();
      chk("mdu_cnt", cnt_a, 32'd5);
      chk("mdu_no_to", 32'(to_a), 32'd0);
      chk("wd_cnt", 32'(cnt_t), 32'd4);
      chk("wd_sticky", 32'(to_t), 32'd1);

      // saturation of the 3-bit counter
      for (int i = 0; i < 5; i++) begin
         adv(); load(5'd9, 5'd0, 0, 5'd9, 1);
      end
      adv(); idle(); settle();
      chk("sat_cnt_t", 32'(cnt_t), 32'd7);
      chk("sat_cnt_a", cnt_a, 32'd10);

      // done in the same cycle the watchdog expires
      adv(); rst = 1; adv(); rst = 0;
      mdu_start = 1; adv(); idle(); adv(); adv(); adv();
      mdu_done = 1; settle();
      chk("race_scour", 32'(ex_sc_t), 32'd0);
      chk("race_hold", 32'(pc_hold_t), 32'd0);
      adv(); idle(); settle();
      chk("race_no_flag", 32'(to_t), 32'd0);
      chk("race_state", 32'(st_t), 32'(RUN));

      // asynchronous reset in the middle of an MDU wait
      adv(); mdu_start = 1; adv(); idle(); adv();
      #2 rst = 1;
      #1;
      chk("arst_hold_a", 32'(pc_hold_a), 32'd0);
      chk("arst_hold_t", 32'(ex_hold_t), 32'd0);
      chk("arst_state", 32'(st_a), 32'(RUN));
      chk("arst_cnt", cnt_a, 32'd0);
      settle();
      adv(); rst = 0; settle();
      chk("arst_after", 32'(pc_hold_a), 32'd0);

      adv();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
